// File: rtl/poly_pkg.sv
// Shared definitions for the polynomial command pipeline (fetch and execute).
// Holds opcode and error encodings, the empty-slot degree marker, the
// highest legal degree and the execute-stage state enumeration.
package poly_pkg;

    localparam logic [7:0] OP_STP = 8'd0;
    localparam logic [7:0] OP_OUT = 8'd1;
    localparam logic [7:0] OP_EVP = 8'd2;
    localparam logic [7:0] OP_RST = 8'd3;

    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_OPCODE = 2'd1;
    localparam logic [1:0] ERR_DEGREE = 2'd2;
    localparam logic [1:0] ERR_UNDEF  = 2'd3;

    localparam logic [3:0] N_EMPTY = 4'd15;
    localparam int         MAX_DEG = 10;
    localparam int         N_SLOTS = 8;

    typedef enum logic [3:0] {
        IDLE,
        DECODE,
        ERR_OUT,
        STP_RD,
        OUT_WR,
        EVP_RDX,
        EVP_MAC,
        EVP_WR,
        RST_CLR,
        DONE
    } state_t;

endpackage

// File: rtl/poly_coeff_mem.sv
// Coefficient store: N_SLOTS slots of MAX_DEG+1 signed words each.
// One synchronous write port, one combinational read port, both addressed
// by {slot, k}. Indices above MAX_DEG are ignored on write and read as 0.
// Ports:
//   clk                       clock
//   we, wr_slot, wr_k, wr_data  write port
//   rd_slot, rd_k, rd_data      read port
module poly_coeff_mem #(
    parameter int DATA_W  = 16,
    parameter int MAX_DEG = 10
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [2:0]               wr_slot,
    input  logic [3:0]               wr_k,
    input  logic signed [DATA_W-1:0] wr_data,
    input  logic [2:0]               rd_slot,
    input  logic [3:0]               rd_k,
    output logic signed [DATA_W-1:0] rd_data
);
    import poly_pkg::*;

    logic signed [DATA_W-1:0] mem [N_SLOTS][MAX_DEG+1];

    always_ff @(posedge clk) begin
        if (we && (int'(wr_k) <= MAX_DEG)) begin
            mem[wr_slot][wr_k] <= wr_data;
        end
    end

    assign rd_data = (int'(rd_k) <= MAX_DEG) ? mem[rd_slot][rd_k] : '0;

endmodule

// File: rtl/proc_command_fsm.sv
// Execute stage of the polynomial command pipeline. Runs one decoded command
// (store, output, Horner evaluate, clear) against the 8-slot coefficient
// store and owns the per-slot degree table N[] read by the fetch stage.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start_proc_cmd            command pulse; instr/arg1/arg2/error held until done
//   instr, arg1, arg2, error  decoded command from fetch
//   din, din_valid, en_rd_data   input word stream (pop when en_rd_data)
//   dout, dout_wr, dout_full     output word stream (push when dout_wr)
//   N                         degree per slot, 15 = empty
//   done_proc_cmd, busy       completion pulse, not-idle flag
module proc_command_fsm #(
    parameter int DATA_W  = 16,
    parameter int RES_W   = 32,
    parameter int MAX_DEG = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_proc_cmd,
    input  logic [7:0]               instr,
    input  logic [2:0]               arg1,
    input  logic [4:0]               arg2,
    input  logic [1:0]               error,
    input  logic signed [DATA_W-1:0] din,
    input  logic                     din_valid,
    output logic                     en_rd_data,
    output logic [RES_W-1:0]         dout,
    output logic                     dout_wr,
    input  logic                     dout_full,
    output logic [7:0][3:0]          N,
    output logic                     done_proc_cmd,
    output logic                     busy
);
    import poly_pkg::*;

    state_t                   state, state_nxt;
    logic [3:0]               k, k_nxt;
    logic signed [RES_W-1:0]  acc, acc_nxt;
    logic signed [DATA_W-1:0] x, x_nxt;
    logic [7:0][3:0]          n_tab, n_nxt;
    logic                     mem_we;
    logic [3:0]               rd_k;
    logic signed [DATA_W-1:0] rd_data;
    logic [3:0]               deg;

    function automatic logic signed [RES_W-1:0] sext(input logic signed [DATA_W-1:0] v);
        return RES_W'(v);
    endfunction

    // One Horner step; the product and sum simply wrap modulo 2^RES_W.
    function automatic logic signed [RES_W-1:0] mac_wrap(
        input logic signed [RES_W-1:0] a,
        input logic signed [RES_W-1:0] m,
        input logic signed [RES_W-1:0] c
    );
        return a * m + c;
    endfunction

    poly_coeff_mem #(.DATA_W(DATA_W), .MAX_DEG(MAX_DEG)) u_mem (
        .clk     (clk),
        .we      (mem_we),
        .wr_slot (arg1),
        .wr_k    (k),
        .wr_data (din),
        .rd_slot (arg1),
        .rd_k    (rd_k),
        .rd_data (rd_data)
    );

    assign deg = n_tab[arg1];

    // Control state
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            k     <= '0;
            n_tab <= {8{N_EMPTY}};
        end else begin
            state <= state_nxt;
            k     <= k_nxt;
            n_tab <= n_nxt;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        acc <= acc_nxt;
        x   <= x_nxt;
    end

    always_comb begin
        state_nxt  = state;
        k_nxt      = k;
        acc_nxt    = acc;
        x_nxt      = x;
        n_nxt      = n_tab;
        mem_we     = 1'b0;
        rd_k       = k;
        dout       = '0;
        dout_wr    = 1'b0;
        en_rd_data = 1'b0;

        case (state)
            IDLE: begin
                if (start_proc_cmd) state_nxt = DECODE;
            end
            DECODE: begin
                k_nxt = '0;
                if (error != ERR_NONE) begin
                    state_nxt = ERR_OUT;
                end else begin
                    case (instr)
                        OP_STP:  state_nxt = STP_RD;
                        OP_OUT:  state_nxt = OUT_WR;
                        OP_EVP:  state_nxt = EVP_RDX;
                        OP_RST:  state_nxt = RST_CLR;
                        default: state_nxt = DONE;
                    endcase
                end
            end
            ERR_OUT: begin
                dout = RES_W'(error);
                if (!dout_full) begin
                    dout_wr   = 1'b1;
                    state_nxt = DONE;
                end
            end
            STP_RD: begin
                if (din_valid) begin
                    en_rd_data = 1'b1;
                    mem_we     = 1'b1;
                    k_nxt      = k + 4'd1;
                    // Degree is published only with the final coefficient.
                    if ({1'b0, k} == arg2) begin
                        n_nxt[arg1] = arg2[3:0];
                        state_nxt   = DONE;
                    end
                end
            end
            OUT_WR: begin
                dout = sext(rd_data);
                if (!dout_full) begin
                    dout_wr = 1'b1;
                    k_nxt   = k + 4'd1;
                    if (k == deg) state_nxt = DONE;
                end
            end
            EVP_RDX: begin
                rd_k = deg;
                if (din_valid) begin
                    en_rd_data = 1'b1;
                    x_nxt      = din;
                    acc_nxt    = sext(rd_data);
                    k_nxt      = deg;
                    state_nxt  = (deg == 4'd0) ? EVP_WR : EVP_MAC;
                end
            end
            EVP_MAC: begin
                // Entered only with k >= 1; the last step (k == 1) leaves.
                rd_k    = k - 4'd1;
                acc_nxt = mac_wrap(acc, sext(x), sext(rd_data));
                k_nxt   = k - 4'd1;
                if (k == 4'd1) state_nxt = EVP_WR;
            end
            EVP_WR: begin
                dout = acc;
                if (!dout_full) begin
                    dout_wr   = 1'b1;
                    state_nxt = DONE;
                end
            end
            RST_CLR: begin
                n_nxt     = {8{N_EMPTY}};
                state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign N             = n_tab;
    assign busy          = (state != IDLE);
    assign done_proc_cmd = (state == DONE);

endmodule

// File: tb/tb_proc_command_fsm.sv
// Directed bench for proc_command_fsm. Inputs change on the falling edge;
// a side process feeds din from a queue and logs every pushed dout word.
module tb_proc_command_fsm;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start_proc_cmd = 1'b0;
    logic [7:0]         instr = '0;
    logic [2:0]         arg1 = '0;
    logic [4:0]         arg2 = '0;
    logic [1:0]         error = '0;
    logic signed [15:0] din = '0;
    logic               din_valid = 1'b0;
    logic               en_rd_data;
    logic [31:0]        dout;
    logic               dout_wr;
    logic               dout_full = 1'b0;
    logic [7:0][3:0]    N;
    logic               done_proc_cmd;
    logic               busy;

    int total = 0;
    int bad   = 0;

    logic signed [15:0] feed_q [$];
    logic [31:0]        out_log [256];
    int                 wr_cnt  = 0;
    int                 pop_cnt = 0;
    logic               pop_s   = 1'b0;

    proc_command_fsm dut (
        .clk            (clk),
        .rst            (rst),
        .start_proc_cmd (start_proc_cmd),
        .instr          (instr),
        .arg1           (arg1),
        .arg2           (arg2),
        .error          (error),
        .din            (din),
        .din_valid      (din_valid),
        .en_rd_data     (en_rd_data),
        .dout           (dout),
        .dout_wr        (dout_wr),
        .dout_full      (dout_full),
        .N              (N),
        .done_proc_cmd  (done_proc_cmd),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // Sample handshakes well inside the low phase, after inputs settle.
    always @(negedge clk) begin
        #2;
        pop_s = en_rd_data && !rst;
        if (dout_wr && !rst && wr_cnt < 256) begin
            out_log[wr_cnt] = dout;
            wr_cnt++;
        end
    end

    // Retire popped words just after the edge that consumed them.
    always @(posedge clk) begin
        logic signed [15:0] junk;
        #1;
        if (pop_s && feed_q.size() > 0) begin
            junk = feed_q.pop_front();
            pop_cnt++;
        end
        pop_s     = 1'b0;
        din_valid = (feed_q.size() > 0);
        din       = (feed_q.size() > 0) ? feed_q[0] : 16'sd0;
    end

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Call on a falling edge; returns on the next falling edge (DECODE cycle).
    task automatic issue(input logic [7:0] op, input logic [2:0] a1,
                         input logic [4:0] a2, input logic [1:0] err);
        instr = op; arg1 = a1; arg2 = a2; error = err;
        start_proc_cmd = 1'b1;
        @(negedge clk);
        start_proc_cmd = 1'b0;
    endtask

    // Cycle count is inclusive of the start cycle (1) and the done cycle.
    task automatic wait_done(input string tag, input int c0, input int exp_lat);
        int c = c0;
        while (done_proc_cmd !== 1'b1 && c < 80) begin
            @(negedge clk);
            c++;
        end
        chk({tag, "_lat"}, c, exp_lat);
        @(negedge clk);
        chk({tag, "_pulse1"}, {31'd0, done_proc_cmd}, 32'd0);
    endtask

    // Power-sum form, wrapped to 32 bits.
    function automatic logic [31:0] poly_ref(input int d, input logic signed [15:0] c [11],
                                             input logic signed [15:0] xv);
        longint s = 0;
        longint p = 1;
        for (int i = 0; i <= d; i++) begin
            s += longint'(c[i]) * p;
            p *= longint'(xv);
        end
        return s[31:0];
    endfunction

    initial begin
        logic signed [15:0] cf [11];
        int b;
        int p0;

        // Reset
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_N", N, 32'hFFFF_FFFF);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done_proc_cmd}, 32'd0);
        chk("rst_pop", {31'd0, en_rd_data}, 32'd0);
        chk("rst_wr", {31'd0, dout_wr}, 32'd0);
        chk("rst_dout", dout, 32'd0);

        // STP slot 2, degree 2, coefficients 1,2,3
        feed_q.push_back(16'sd1); feed_q.push_back(16'sd2); feed_q.push_back(16'sd3);
        p0 = pop_cnt;
        @(negedge clk);
        issue(8'd0, 3'd2, 5'd2, 2'd0);
        chk("stp2_busy", {31'd0, busy}, 32'd1);
        wait_done("stp2", 2, 6);
        chk("stp2_pops", pop_cnt - p0, 32'd3);
        chk("stp2_N", N, 32'hFFFF_F2FF);

        // EVP slot 2 at x=2: 1 + 2*2 + 3*4 = 17
        feed_q.push_back(16'sd2);
        b = wr_cnt; p0 = pop_cnt;
        @(negedge clk);
        issue(8'd2, 3'd2, 5'd0, 2'd0);
        wait_done("evp2", 2, 7);
        chk("evp2_nwr", wr_cnt - b, 32'd1);
        chk("evp2_val", out_log[b], 32'd17);
        chk("evp2_pops", pop_cnt - p0, 32'd1);

        // OUT slot 2 with a 3-cycle back-pressure after the first word
        b = wr_cnt;
        issue(8'd1, 3'd2, 5'd0, 2'd0);
        @(negedge clk);
        @(negedge clk);
        dout_full = 1'b1;
        repeat (3) @(negedge clk);
        dout_full = 1'b0;
        wait_done("out2", 7, 9);
        chk("out2_nwr", wr_cnt - b, 32'd3);
        chk("out2_w0", out_log[b], 32'd1);
        chk("out2_w1", out_log[b+1], 32'd2);
        chk("out2_w2", out_log[b+2], 32'd3);

        // Error 3 on an EVP: one status word, din untouched
        feed_q.push_back(16'sd32767);
        b = wr_cnt; p0 = pop_cnt;
        @(negedge clk);
        issue(8'd2, 3'd5, 5'd0, 2'd3);
        wait_done("err", 2, 4);
        chk("err_nwr", wr_cnt - b, 32'd1);
        chk("err_val", out_log[b], 32'd3);
        chk("err_pops", pop_cnt - p0, 32'd0);
        chk("err_N", N, 32'hFFFF_F2FF);

        // STP slot 6, degree 3, extreme coefficients (first one already queued)
        cf[0] = 16'sd32767; cf[1] = -16'sd32768; cf[2] = 16'sd32767; cf[3] = 16'sd32767;
        for (int i = 1; i <= 3; i++) feed_q.push_back(cf[i]);
        issue(8'd0, 3'd6, 5'd3, 2'd0);
        wait_done("stp6", 2, 7);
        chk("stp6_N", N, 32'hF3FF_F2FF);

        // EVP slot 6 at x=32767, result wraps
        feed_q.push_back(16'sd32767);
        b = wr_cnt;
        @(negedge clk);
        issue(8'd2, 3'd6, 5'd0, 2'd0);
        wait_done("evp6", 2, 8);
        chk("evp6_val", out_log[b], poly_ref(3, cf, 16'sd32767));

        // STP slot 7 at the maximum degree, mixed-sign coefficients
        for (int i = 0; i <= 10; i++) begin
            cf[i] = 16'(i * 100 - 500);
            feed_q.push_back(cf[i]);
        end
        @(negedge clk);
        issue(8'd0, 3'd7, 5'd10, 2'd0);
        wait_done("stp7", 2, 14);
        chk("stp7_N", N, 32'hA3FF_F2FF);

        // OUT slot 7: all 11 words, sign-extended
        b = wr_cnt;
        issue(8'd1, 3'd7, 5'd0, 2'd0);
        wait_done("out7", 2, 14);
        chk("out7_nwr", wr_cnt - b, 32'd11);
        for (int i = 0; i <= 10; i++) chk($sformatf("out7_w%0d", i), out_log[b+i], 32'(cf[i]));

        // EVP slot 7 at x=-2
        feed_q.push_back(-16'sd2);
        b = wr_cnt;
        @(negedge clk);
        issue(8'd2, 3'd7, 5'd0, 2'd0);
        wait_done("evp7", 2, 15);
        chk("evp7_val", out_log[b], poly_ref(10, cf, -16'sd2));

        // Clear all slots
        issue(8'd3, 3'd0, 5'd0, 2'd0);
        wait_done("clr", 2, 4);
        chk("clr_N", N, 32'hFFFF_FFFF);

        // Reset in the middle of an STP after one pop
        feed_q.push_back(16'sd10);
        p0 = pop_cnt;
        @(negedge clk);
        issue(8'd0, 3'd1, 5'd2, 2'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_pops", pop_cnt - p0, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_N", N, 32'hFFFF_FFFF);

        // Degree-0 store and evaluate after the abort
        feed_q.push_back(16'sd5);
        @(negedge clk);
        issue(8'd0, 3'd1, 5'd0, 2'd0);
        wait_done("stp1", 2, 4);
        chk("stp1_N", N, 32'hFFFF_FF0F);
        feed_q.push_back(-16'sd3);
        b = wr_cnt;
        @(negedge clk);
        issue(8'd2, 3'd1, 5'd0, 2'd0);
        wait_done("evp1", 2, 5);
        chk("evp1_val", out_log[b], 32'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
